// File: rtl/filter_pkg.sv
// Shared types and constants for the FILTER result reader.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    localparam int ERR_DROP  = 0;
    localparam int ERR_ACC   = 1;
    localparam int ERR_TRIG  = 2;
    localparam int ERR_W     = 3;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/filter_result_fifo.sv
// Synchronous FIFO with a first-word-fall-through output register.
// Capacity is DEPTH entries counting the output register.
module filter_result_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] out_q, out_d;
    logic          ov_q, ov_d;
    logic          mem_we;
    logic          pop;

    assign pop     = pop_i & ov_q;
    assign data_o  = out_q;
    assign valid_o = ov_q;
    assign empty_o = ~ov_q;
    assign level_o = cnt_q + {{(LW-1){1'b0}}, ov_q};
    assign full_o  = (level_o == LW'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ov_d     = ov_q;
        mem_we   = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            out_d    = '0;
            ov_d     = 1'b0;
        end else if (!ov_q) begin
            if (push_i) begin
                out_d = data_i;
                ov_d  = 1'b1;
            end
        end else if (pop) begin
            if (cnt_q != '0) begin
                // Refill the output register from storage; a push keeps the count.
                out_d    = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
                cnt_d    = cnt_q - LW'(1);
                if (push_i) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    cnt_d    = cnt_q;
                end
            end else if (push_i) begin
                out_d = data_i;
            end else begin
                ov_d = 1'b0;
            end
        end else if (push_i) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ov_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ov_q     <= ov_d;
        end
    end

endmodule

// File: rtl/filter_result_reader.sv
// Consumer of FILTER results: session FSM, result counter, sticky errors
// and a buffered valid/ready output stream.
module filter_result_reader
    import filter_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             ready_i,
    input  logic [DW-1:0]    data_i,
    input  logic [1:0]       ferr_i,
    output logic [DW-1:0]    m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [31:0]      count_o,
    output logic [LW-1:0]    level_o,
    output logic [ERR_W-1:0] err_o
);
    state_e           state_q, state_d;
    logic             en_q;
    logic [31:0]      count_q, count_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic rise, fall, capt, pop, strobe, push, drop, full, empty;

    assign rise   = enable_i & ~en_q;
    assign fall   = ~enable_i & en_q;
    assign capt   = (state_q == CAPTURE);
    assign pop    = m_valid_o & m_ready_i;
    // A re-arm flushes, so a strobe in the arming cycle is discarded.
    assign strobe = capt & ready_i & ~rise;
    assign push   = strobe & (~full | pop);
    assign drop   = strobe & full & ~pop;

    filter_result_fifo #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (rise),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (pop),
        .data_o  (m_data_o),
        .valid_o (m_valid_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            CAPTURE: if (fall) state_d = DRAIN;
            DRAIN:   if (empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rise) begin
            state_d = CAPTURE;
            count_d = '0;
            err_d   = '0;
        end else begin
            if (push) count_d = count_q + 32'd1;
            if (drop) err_d[ERR_DROP] = 1'b1;
            if (capt) err_d[ERR_TRIG:ERR_ACC] = err_q[ERR_TRIG:ERR_ACC] | ferr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= enable_i;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_filter_result_reader.sv
// Directed self-checking bench for filter_result_reader (DW=32, DEPTH=16).
module tb_filter_result_reader;
    logic        clk = 1'b0;
    logic        reset_i, enable_i, ready_i, m_ready_i;
    logic [31:0] data_i;
    logic [1:0]  ferr_i;
    logic [31:0] m_data_o, count_o;
    logic        m_valid_o;
    logic [4:0]  level_o;
    logic [2:0]  err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    filter_result_reader #(.DW(32), .DEPTH(16)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .ready_i   (ready_i),
        .data_i    (data_i),
        .ferr_i    (ferr_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .count_o   (count_o),
        .level_o   (level_o),
        .err_o     (err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b0; ready_i = 1'b0; m_ready_i = 1'b0;
        data_i = '0; ferr_i = '0;
        step(); step();
        reset_i = 1'b0;
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_err", err_o, 0);

        // 1: strobes while idle are ignored
        ready_i = 1'b1; data_i = 32'd55;
        step(); step();
        ready_i = 1'b0;
        chk("idle_valid", m_valid_o, 0);
        chk("idle_count", count_o, 0);
        chk("idle_err", err_o, 0);

        // 2: arm, three alternate-cycle strobes with downstream ready
        enable_i = 1'b1; m_ready_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            ready_i = 1'b1; data_i = 32'(10 * (i + 1));
            step();
            chk("t2_valid", m_valid_o, 1);
            chk("t2_data", m_data_o, 10 * (i + 1));
            ready_i = 1'b0;
            step();
            chk("t2_popped", m_valid_o, 0);
        end
        chk("t2_count", count_o, 3);

        // re-arm for a fresh session
        enable_i = 1'b0; step();
        enable_i = 1'b1; step();
        chk("rearm_count", count_o, 0);
        chk("rearm_level", level_o, 0);

        // 3/4: fill to DEPTH with downstream stalled
        m_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ready_i = 1'b1; data_i = 32'(100 + i);
            step();
        end
        chk("full_level", level_o, 16);
        chk("full_err", err_o, 0);
        chk("full_count", count_o, 16);
        chk("full_hold", m_data_o, 100);
        // full, strobe plus pop same cycle: accepted
        data_i = 32'd116; m_ready_i = 1'b1;
        step();
        chk("pp_level", level_o, 16);
        chk("pp_err", err_o, 0);
        chk("pp_count", count_o, 17);
        chk("pp_data", m_data_o, 101);
        // full, strobe without pop: dropped
        data_i = 32'd117; m_ready_i = 1'b0;
        step();
        chk("drop_err", err_o, 3'b001);
        chk("drop_count", count_o, 17);
        chk("drop_level", level_o, 16);
        // drain: exactly the 16 held values, in order
        ready_i = 1'b0; m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", m_valid_o, 1);
            chk("drain_data", m_data_o, 101 + i);
            step();
        end
        chk("drain_empty", m_valid_o, 0);
        chk("drain_level", level_o, 0);

        // 5: filter error flags are sticky, cleared by re-arm
        enable_i = 1'b0; step();
        enable_i = 1'b1; step();
        chk("t5_clear", err_o, 0);
        ferr_i = 2'b10; step();
        ferr_i = 2'b00; step();
        chk("t5_trig", err_o, 3'b100);
        step();
        chk("t5_sticky", err_o, 3'b100);
        ferr_i = 2'b01; step();
        ferr_i = 2'b00;
        chk("t5_acc", err_o, 3'b110);
        enable_i = 1'b0; step();
        enable_i = 1'b1; step();
        chk("t5_rearm", err_o, 0);

        // 6: drop enable with 5 queued, drain them, then ignore strobes
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ready_i = 1'b1; data_i = 32'(300 + i);
            step();
        end
        chk("t6_level", level_o, 5);
        enable_i = 1'b0; ready_i = 1'b0; step();
        ready_i = 1'b1; data_i = 32'd999; step();
        ready_i = 1'b0;
        chk("t6_ign_level", level_o, 5);
        chk("t6_ign_count", count_o, 5);
        m_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t6_data", m_data_o, 300 + i);
            step();
        end
        chk("t6_empty", m_valid_o, 0);
        step();
        ready_i = 1'b1; data_i = 32'd888; step(); step();
        ready_i = 1'b0;
        chk("t6_idle_valid", m_valid_o, 0);
        chk("t6_idle_count", count_o, 5);

        // reset overrides a simultaneous re-arm
        enable_i = 1'b1; m_ready_i = 1'b0; step();
        ready_i = 1'b1; data_i = 32'd7; step(); step();
        ready_i = 1'b0;
        chk("pre_rst_level", level_o, 2);
        enable_i = 1'b0; step();
        enable_i = 1'b1; reset_i = 1'b1; step();
        reset_i = 1'b0;
        chk("rst2_level", level_o, 0);
        chk("rst2_count", count_o, 0);
        chk("rst2_valid", m_valid_o, 0);
        chk("rst2_data", m_data_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
